// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM state encoding
// and small decode helpers used by the datapath and the load aligner.
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } mem_op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Codes 9-15 fall into the default arm and behave as NOP everywhere.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return |off;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << off;
            OP_LH, OP_LHU, OP_SH: return off[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] data);
        case (op)
            OP_SB:   return {4{data[7:0]}};
            OP_SH:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack port: the MEM stage is the master, the memory the slave.
interface mem_access_if;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_load_align.sv
// Little-endian byte/halfword extraction with sign or zero extension of a
// read word; purely combinational.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    // NOTE: every path assigns o_data (default arm included), so no latch is inferred.
    always_comb begin
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h000000, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0000, w_half};
            OP_LW:   o_data = i_rdata;
            default: o_data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a req/ack data port, stalls the
// pipeline while a transaction is outstanding, passes other ops straight through.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [3:0]  memOp,
    input  logic [31:0] memAddr,
    input  logic [31:0] storeData,
    input  logic [4:0]  regAddr_i,
    input  logic        regWr_i,
    input  logic [31:0] regData_i,
    mem_access_if.master dm,
    output logic [31:0] inst_o,
    output logic [4:0]  regAddr,
    output logic        regWr,
    output logic [31:0] regData,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err
);

    logic [1:0]    r_state;
    logic [3:0]    r_op;
    logic [31:0]   r_addr;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [4:0]    r_reg_addr;
    logic          r_reg_wr;
    logic [31:0]   r_inst;
    logic [31:0]   r_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic          r_bus_err;

    logic          w_mem_op;
    logic          w_misalign;
    logic          w_start;
    logic [31:0]   w_load_data;

    assign w_mem_op   = is_load(memOp) || is_store(memOp);
    assign w_misalign = w_mem_op && is_misaligned(memOp, memAddr[1:0]);
    assign w_start    = (r_state == S_IDLE) && w_mem_op && !w_misalign;

    load_align u_load_align (
        .i_rdata (dm.dm_rdata),
        .i_off   (r_addr[1:0]),
        .i_op    (r_op),
        .o_data  (w_load_data)
    );

    assign dm.dm_req   = r_req;
    assign dm.dm_we    = r_we;
    assign dm.dm_be    = r_be;
    assign dm.dm_addr  = {r_addr[31:2], 2'b00};
    assign dm.dm_wdata = r_wdata;
    assign bus_err     = r_bus_err;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the latched request fields are plain registers, so clearing them on reset is cheap.
            r_state    <= S_IDLE;
            r_op       <= 4'h0;
            r_addr     <= ZeroWord;
            r_we       <= 1'b0;
            r_be       <= 4'h0;
            r_wdata    <= ZeroWord;
            r_reg_addr <= 5'd0;
            r_reg_wr   <= 1'b0;
            r_inst     <= ZeroWord;
            r_rdata    <= ZeroWord;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op       <= memOp;
                        r_addr     <= memAddr;
                        r_we       <= is_store(memOp);
                        r_be       <= byte_en(memOp, memAddr[1:0]);
                        r_wdata    <= store_data(memOp, storeData);
                        r_reg_addr <= regAddr_i;
                        r_reg_wr   <= regWr_i;
                        r_inst     <= inst_i;
                        r_rdata    <= ZeroWord;
                        r_cnt      <= '0;
                        r_req      <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (dm.dm_ack) begin
                        r_rdata <= is_store(r_op) ? ZeroWord : w_load_data;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_bus_err <= 1'b1;
                        r_req     <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_bus_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        inst_o   = ZeroWord;
        regAddr  = 5'd0;
        regWr    = 1'b0;
        regData  = ZeroWord;
        stallreq = 1'b0;
        misalign = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    inst_o   = inst_i;
                    regAddr  = regAddr_i;
                    regWr    = regWr_i && !w_mem_op;
                    regData  = regData_i;
                    stallreq = w_start;
                    misalign = w_misalign;
                end
                S_BUSY: begin
                    inst_o   = r_inst;
                    regAddr  = r_reg_addr;
                    stallreq = 1'b1;
                end
                S_DONE: begin
                    inst_o  = r_inst;
                    regAddr = r_reg_addr;
                    regData = r_rdata;
                    regWr   = r_reg_wr && is_load(r_op) && !r_bus_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: load_align vector table, directed
// corner sequences, and randomized ops against a word-array memory model.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic [3:0]  memOp;
    logic [31:0] memAddr;
    logic [31:0] storeData;
    logic [4:0]  regAddr_i;
    logic        regWr_i;
    logic [31:0] regData_i;
    logic [31:0] inst_o;
    logic [4:0]  regAddr;
    logic        regWr;
    logic [31:0] regData;
    logic        stallreq;
    logic        misalign;
    logic        bus_err;

    mem_access_if dm_bus ();

    mem_access #(.TIMEOUT(16), .CW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_i    (inst_i),
        .memOp     (memOp),
        .memAddr   (memAddr),
        .storeData (storeData),
        .regAddr_i (regAddr_i),
        .regWr_i   (regWr_i),
        .regData_i (regData_i),
        .dm        (dm_bus),
        .inst_o    (inst_o),
        .regAddr   (regAddr),
        .regWr     (regWr),
        .regData   (regData),
        .stallreq  (stallreq),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    logic [31:0] t_rdata;
    logic [1:0]  t_off;
    logic [3:0]  t_op;
    logic [31:0] t_out;

    load_align u_ref (
        .i_rdata (t_rdata),
        .i_off   (t_off),
        .i_op    (t_op),
        .o_data  (t_out)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  off;
        logic [3:0]  op;
        logic [31:0] exp;
    } la_vec_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] smem [16];
    logic [31:0] mmem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [3:0] op);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            2:       return b;
            3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4:       return h;
            5:       return w;
            default: return 32'h0;
        endcase
    endfunction

    // One instruction from EX_MEM; k = BUSY cycle carrying the ack (k > 16: never).
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd, input int k);
        logic [31:0] inst, rdi, mask, val;
        logic [4:0]  ra;
        logic        rw, ld, st, mis, err;
        int          size, idx, last;
        inst = $urandom;
        rdi  = $urandom;
        ra   = 5'($urandom_range(0, 31));
        rw   = 1'($urandom_range(0, 1));
        ld   = (op >= 1) && (op <= 5);
        st   = (op >= 6) && (op <= 8);
        size = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
        mis  = (ld || st) && ((addr & 32'(size - 1)) != 0);
        inst_i = inst; memOp = op; memAddr = addr; storeData = sd;
        regAddr_i = ra; regWr_i = rw; regData_i = rdi;
        @(negedge clk);
        check("idle_stallreq", stallreq, (ld || st) && !mis);
        check("idle_misalign", misalign, mis);
        check("idle_bus_err", bus_err, 0);
        if (!(ld || st)) begin
            check("pass_regdata", regData, rdi);
            check("pass_regwr", regWr, rw);
            check("pass_regaddr", regAddr, ra);
            check("pass_inst", inst_o, inst);
        end else begin
            check("idle_memop_regwr", regWr, 0);
        end
        @(posedge clk); #1;
        if (!(ld || st) || mis) begin
            check("no_req", dm_bus.dm_req, 0);
            return;
        end
        idx  = int'(addr[5:2]);
        err  = (k > 16);
        last = err ? 16 : k;
        for (int i = 1; i <= last; i++) begin
            dm_bus.dm_ack   = (i == k);
            dm_bus.dm_rdata = smem[idx];
            @(negedge clk);
            check("busy_req", dm_bus.dm_req, 1);
            check("busy_stallreq", stallreq, 1);
            check("busy_addr", dm_bus.dm_addr, addr & 32'hFFFF_FFFC);
            check("busy_we", dm_bus.dm_we, st);
            if (st) begin
                check("busy_be", dm_bus.dm_be,
                      (op == 6) ? 32'(4'b0001 << addr[1:0]) : (op == 7) ? (addr[1] ? 32'hC : 32'h3) : 32'hF);
                check("busy_wdata", dm_bus.dm_wdata,
                      (op == 6) ? (sd & 32'hFF) * 32'h0101_0101 : (op == 7) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd);
                if (i == k)
                    for (int b = 0; b < 4; b++)
                        if (dm_bus.dm_be[b]) smem[idx][8*b +: 8] = dm_bus.dm_wdata[8*b +: 8];
            end
            @(posedge clk); #1;
        end
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = $urandom;
        @(negedge clk);
        check("done_stallreq", stallreq, 0);
        check("done_req", dm_bus.dm_req, 0);
        check("done_bus_err", bus_err, err);
        check("done_regwr", regWr, ld && rw && !err);
        check("done_regaddr", regAddr, ra);
        check("done_inst", inst_o, inst);
        if (!err && ld) check("done_load_data", regData, ref_load(mmem[idx], addr[1:0], op));
        if (!err && st) begin
            check("done_store_regdata", regData, 0);
            mask = (op == 6) ? 32'hFF << (8 * addr[1:0]) : (op == 7) ? 32'hFFFF << (16 * addr[1]) : 32'hFFFF_FFFF;
            val  = (sd << ((op == 6) ? 8 * addr[1:0] : (op == 7) ? 16 * addr[1] : 0)) & mask;
            mmem[idx] = (mmem[idx] & ~mask) | val;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        la_vec_t     vecs [10];
        logic [3:0]  op;
        logic [31:0] addr;
        int          k;

        vecs[0] = '{32'h80FF_0000, 2'd3, OP_LB,  32'hFFFF_FF80};
        vecs[1] = '{32'h80FF_0000, 2'd2, OP_LB,  32'hFFFF_FFFF};
        vecs[2] = '{32'h80FF_0000, 2'd2, OP_LBU, 32'h0000_00FF};
        vecs[3] = '{32'h80FF_0000, 2'd0, OP_LBU, 32'h0000_0000};
        vecs[4] = '{32'h80FF_0000, 2'd2, OP_LH,  32'hFFFF_80FF};
        vecs[5] = '{32'h1234_8765, 2'd0, OP_LH,  32'hFFFF_8765};
        vecs[6] = '{32'h1234_8765, 2'd0, OP_LHU, 32'h0000_8765};
        vecs[7] = '{32'h1234_8765, 2'd2, OP_LHU, 32'h0000_1234};
        vecs[8] = '{32'hDEAD_BEEF, 2'd0, OP_LW,  32'hDEAD_BEEF};
        vecs[9] = '{32'h0000_7F00, 2'd1, OP_LB,  32'h0000_007F};

        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom;
            mmem[i] = smem[i];
        end

        // Reset with a live aligned load on the inputs: outputs must stay quiet.
        rst = 1'b1; dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = 32'h0;
        inst_i = 32'hCAFE_0001; memOp = OP_LW; memAddr = 32'h0000_0040; storeData = 32'h5555_AAAA;
        regAddr_i = 5'd7; regWr_i = 1'b1; regData_i = 32'h0000_0099;
        @(negedge clk);
        check("rst_stallreq", stallreq, 0);
        check("rst_regwr", regWr, 0);
        check("rst_inst", inst_o, 0);
        check("rst_regdata", regData, 0);
        check("rst_regaddr", regAddr, 0);
        @(negedge clk);
        check("rst_req", dm_bus.dm_req, 0);
        check("rst_we", dm_bus.dm_we, 0);
        check("rst_be", dm_bus.dm_be, 0);
        check("rst_addr", dm_bus.dm_addr, 0);
        check("rst_wdata", dm_bus.dm_wdata, 0);
        check("rst_bus_err", bus_err, 0);
        @(posedge clk); #1;
        rst = 1'b0; memOp = OP_NOP;

        for (int i = 0; i < 10; i++) begin
            t_rdata = vecs[i].rdata; t_off = vecs[i].off; t_op = vecs[i].op;
            #1;
            check($sformatf("load_align_vec%0d", i), t_out, vecs[i].exp);
        end

        @(posedge clk); #1;
        memOp = OP_NOP; regData_i = 32'h0000_1234; regWr_i = 1'b1; regAddr_i = 5'd5; inst_i = 32'h0000_0013;
        @(negedge clk);
        check("nop_regdata", regData, 32'h0000_1234);
        check("nop_regwr", regWr, 1);
        check("nop_regaddr", regAddr, 5);
        check("nop_stallreq", stallreq, 0);
        check("nop_req", dm_bus.dm_req, 0);
        @(posedge clk); #1;

        smem[0] = 32'h80FF_0000; mmem[0] = 32'h80FF_0000;
        run_op(OP_LB, 32'h0000_1003, 32'h0, 1);
        run_op(OP_SH, 32'h0000_2002, 32'hABCD_5678, 3);
        run_op(OP_LH, 32'h0000_2000, 32'h0, 2);
        run_op(OP_LW, 32'h0000_3001, 32'h0, 1);
        run_op(OP_LW, 32'h0000_3004, 32'h0, 99);
        run_op(OP_LW, 32'h0000_3008, 32'h0, 16);
        run_op(4'd12, 32'h0000_3001, 32'h0, 1);

        for (int n = 0; n < 60; n++) begin
            op   = 4'($urandom_range(0, 15));
            addr = 32'h0000_2000 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            k    = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 4);
            run_op(op, addr, $urandom, k);
        end

        // Reset during the second BUSY cycle abandons the load; a late ack is ignored.
        memOp = OP_LW; memAddr = 32'h0000_0044; regWr_i = 1'b1; regData_i = 32'h0000_0777;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_busy1_req", dm_bus.dm_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_stallreq", stallreq, 0);
        check("abort_rst_regwr", regWr, 0);
        @(posedge clk); #1;
        rst = 1'b0; memOp = OP_NOP; dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        check("abort_req_dropped", dm_bus.dm_req, 0);
        check("abort_addr_cleared", dm_bus.dm_addr, 0);
        check("abort_stallreq", stallreq, 0);
        check("abort_pass_regdata", regData, 32'h0000_0777);
        @(posedge clk); #1;
        dm_bus.dm_ack = 1'b0;
        @(negedge clk);
        check("abort_late_ack_req", dm_bus.dm_req, 0);
        check("abort_late_ack_regwr", regWr, 1);
        check("abort_late_ack_bus_err", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage pipeline. Sits between the EX_MEM pipeline register and the MEM_WB register, and feeds MEM_WB's inst_i, regAddr, regWr and regData inputs.
- Performs loads and stores over a req/ack data-memory port, including byte-lane alignment and sign/zero extension.
- Raises stallreq to Ctrl while a memory transaction is outstanding. Ctrl then asserts stall[4:0] with stall[5] low, so MEM_WB inserts a bubble.
- Non-memory instructions pass through combinationally in zero cycles.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles to wait for dm_ack before aborting with bus_err.
- CW, 5, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_i  in  32  instruction from EX_MEM.
- memOp  in  4  memory operation code (package encoding).
- memAddr  in  32  effective address.
- storeData  in  32  rt value for stores.
- regAddr_i  in  5  destination register.
- regWr_i  in  1  write enable from EX.
- regData_i  in  32  ALU result.
- dm_ack  in  1  memory completion, one-cycle pulse.
- dm_rdata  in  32  read word, valid when dm_ack=1.
- inst_o  out  32  to MEM_WB inst_i.
- regAddr  out  5  to MEM_WB.
- regWr  out  1  to MEM_WB.
- regData  out  32  to MEM_WB.
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = store.
- dm_be  out  4  byte enables.
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dm_wdata  out  32  store data, replicated across lanes.
- stallreq  out  1  to Ctrl.
- misalign  out  1  misaligned access flag, same cycle as the offending op.
- bus_err  out  1  timeout flag, valid during DONE.

Behaviour:
- memOp encoding: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9–15 are treated as NOP.
- Misalignment rules:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - A misaligned op issues no request, keeps stallreq=0, forces regWr=0 and sets misalign=1 combinationally.
- States: IDLE, BUSY, DONE.
- IDLE:
  - For an aligned memory op: stallreq=1 combinationally.
  - At the clock edge: latch addr, op, we, be, wdata, regAddr_i, regWr_i and inst_i; set dm_req=1; clear the counter; go to BUSY.
  - Otherwise, pass-through: inst_o=inst_i, regAddr=regAddr_i, regWr=regWr_i (and not misaligned), regData=regData_i.
- BUSY:
  - dm_req=1 and stallreq=1. Request fields come from the latched registers and stay stable.
  - If dm_ack=1: capture the extended load data (stores capture 0), drop dm_req, go to DONE.
  - If dm_ack=0: counter increments. When the counter reaches TIMEOUT-1 without ack: set bus_err, drop dm_req, go to DONE.
- DONE:
  - stallreq=0. Outputs come from the latched registers.
  - Loads: regData = captured value, regWr = latched regWr.
  - Stores: regWr=0.
  - On bus_err: regWr=0.
  - Next edge: go to IDLE and clear bus_err. DONE never re-triggers, because the pipeline advances at this edge.
- Latency: a load occupies IDLE + k BUSY cycles + DONE; minimum 3 cycles with ack on the first BUSY cycle. stallreq is high for k+1 cycles.
- Load extension (little-endian):
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Store data and byte enables:
  - SB: wdata = {4{byte}}, be = 1<<addr[1:0].
  - SH: wdata = {2{half}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
- dm_ack outside BUSY is ignored.
- dm_ack on the same edge as the timeout: ack wins and bus_err stays 0.
- Reset (rst=1 at an edge): state IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, bus_err=0, counter=0, latched registers=0.
  - While rst=1, stallreq=0, regWr=0, inst_o=0, regData=0, regAddr=0.
  - A reset mid-BUSY abandons the transaction; the memory must tolerate a dropped req.

Decomposition:
- Package mem_pkg: memOp codes, the state encoding (IDLE/BUSY/DONE) and the ZeroWord constant.
- Sub-module load_align: combinational extraction and extension from (rdata, addr[1:0], op) to a 32-bit result. Instantiated once and reused by the bench as a reference model.

Test Plan:
- Pass-through: memOp=NOP, regData_i=0x1234, regWr_i=1, regAddr_i=5 -> same-cycle regData=0x1234, regWr=1, regAddr=5, stallreq=0, dm_req=0.
- LB at 0x1003, ack on the 1st BUSY cycle with rdata=0x80FF_0000 -> stallreq high 2 cycles, dm_addr=0x1000, DONE regData=0xFFFF_FF80, regWr=1.
- SH at 0x2002 with storeData=0xABCD_5678, ack after 3 BUSY cycles -> dm_be=0b1100, dm_wdata=0x5678_5678, dm_we=1 held 3 cycles, DONE regWr=0.
- LW at 0x3001 -> misalign=1, dm_req never asserted, regWr=0, stallreq=0.
- LW with no ack and TIMEOUT=16 -> dm_req high 16 cycles, then DONE with bus_err=1 and regWr=0, then IDLE.
- rst=1 during the 2nd BUSY cycle -> next edge dm_req=0 and state IDLE; a later ack pulse is ignored.
